// File: rtl/mcu_ctrl_pkg.sv
// mcu_ctrl_pkg
// Shared encodings for the multicycle MCU controller, its datapath and bench:
// FSM state codes, ALU operation codes, mux-select codes, condition codes and
// the ALU-operation decode helper.
package mcu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_U12 = 2'b00;
    localparam logic [1:0] IMM_B24 = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // funct[4:1] -> ALU operation; unknown opcodes fall back to ADD.
    function automatic logic [1:0] alu_ctrl_decode(input logic [3:0] cmd);
        logic [1:0] op;
        case (cmd)
            4'b0100: op = ALU_ADD;
            4'b0010: op = ALU_SUB;
            4'b0000: op = ALU_AND;
            4'b1100: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mcu_multicycle_ctrl_cond.sv
// mcu_cond_check
// Evaluates the instruction condition field against the registered NZCV flags.
// Ports:
//   cond_i     condition field instr[31:28]
//   nzcv_i     registered flags, N=[3] Z=[2] C=[1] V=[0]
//   cond_ex_o  1 when the instruction should execute
module mcu_cond_check
    import mcu_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       cond_ex_o
);

    logic n, z, v;
    logic unused_carry;

    assign n = nzcv_i[3];
    assign z = nzcv_i[2];
    assign v = nzcv_i[0];
    // No supported condition looks at C.
    assign unused_carry = nzcv_i[1];

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcu_multicycle_ctrl.sv
// mcu_multicycle_ctrl
// Multicycle control FSM: sequences one instruction at a time through
// fetch/decode/execute/memory/writeback, drives datapath selects and write
// enables, holds NZCV and gates execution on the condition field.
// Ports:
//   clk_i          clock, all state on posedge
//   rst_ni         synchronous active-low reset; also forces all outputs to 0
//   instr_i        IR contents (cond/op/funct/rd)
//   alu_flags_i    NZCV from the ALU this cycle
//   pc_write_o, ir_write_o, mem_we_o, reg_we_o       write enables
//   adr_src_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o  datapath selects
//   result_src_o, imm_src_o, reg_src_o               datapath selects
//   illegal_op_o   one-cycle pulse in DECODE for op==11
//   state_o        current state code (debug)
//
// state  | meaning
// FETCH  | IR <= mem[PC], PC <= PC+4
// DECODE | read registers, evaluate condition, dispatch on op
// MEMADR | ALUOut <= base + imm12
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to rd (or PC)
// MEMWR  | write RD2 to memory at ALUOut
// EXECR  | register-register ALU op
// EXECI  | register-immediate ALU op
// ALUWB  | write ALUOut to rd (or PC), optionally update flags
// BRANCH | PC <= PC+8 + sext(imm24)<<2
module mcu_multicycle_ctrl
    import mcu_ctrl_pkg::*;
#(
    parameter int ENABLE_COND = 1,
    parameter int FLAG_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       instr_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    output logic              pc_write_o,
    output logic              ir_write_o,
    output logic              mem_we_o,
    output logic              reg_we_o,
    output logic              adr_src_o,
    output logic              alu_src_a_o,
    output logic [1:0]        alu_src_b_o,
    output logic [1:0]        alu_ctrl_o,
    output logic [1:0]        result_src_o,
    output logic [1:0]        imm_src_o,
    output logic [1:0]        reg_src_o,
    output logic              illegal_op_o,
    output logic [3:0]        state_o
);

    state_t            state_q, state_d;
    logic [FLAG_W-1:0] nzcv_q, nzcv_d;
    logic              cond_ex, cond_ok;
    logic [1:0]        op;
    logic [5:0]        funct;
    logic              rd_is_pc;
    logic              unused_instr_bits;

    assign op       = instr_i[27:26];
    assign funct    = instr_i[25:20];
    assign rd_is_pc = (instr_i[15:12] == 4'hF);
    assign unused_instr_bits = ^{instr_i[19:16], instr_i[11:0]};

    mcu_cond_check u_cond (
        .cond_i    (instr_i[31:28]),
        .nzcv_i    (nzcv_q[3:0]),
        .cond_ex_o (cond_ex)
    );

    assign cond_ok = (ENABLE_COND != 0) ? cond_ex : 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            nzcv_q  <= '0;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        nzcv_d       = nzcv_q;
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_we_o     = 1'b0;
        reg_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_RD2;
        alu_ctrl_o   = ALU_ADD;
        result_src_o = RES_ALUOUT;
        imm_src_o    = IMM_U12;
        illegal_op_o = 1'b0;
        state_o      = state_q;
        // Register address steering follows the IR directly, not the state.
        reg_src_o    = {op == OP_MEM, op == OP_BR};

        case (state_q)
            S_FETCH: begin
                ir_write_o   = 1'b1;
                pc_write_o   = 1'b1;
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
                if (!cond_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   state_d = S_BRANCH;
                        default: begin
                            state_d      = S_FETCH;
                            illegal_op_o = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b_o = SRC_B_IMM;
                state_d     = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src_o = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_o = RES_RDATA;
                pc_write_o   = rd_is_pc;
                reg_we_o     = ~rd_is_pc;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                adr_src_o = 1'b1;
                mem_we_o  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                alu_ctrl_o = alu_ctrl_decode(funct[4:1]);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b_o = SRC_B_IMM;
                alu_ctrl_o  = alu_ctrl_decode(funct[4:1]);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_o = RES_ALUOUT;
                pc_write_o   = rd_is_pc;
                reg_we_o     = ~rd_is_pc;
                if (funct[0]) begin
                    nzcv_d = alu_flags_i;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                imm_src_o    = IMM_B24;
                alu_src_b_o  = SRC_B_IMM;
                result_src_o = RES_ALU;
                pc_write_o   = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                // Unused codes recover to FETCH with every output quiet.
                reg_src_o = 2'b00;
                state_d   = S_FETCH;
            end
        endcase

        // Reset gates every output so nothing is written while it is held.
        if (!rst_ni) begin
            pc_write_o   = 1'b0;
            ir_write_o   = 1'b0;
            mem_we_o     = 1'b0;
            reg_we_o     = 1'b0;
            adr_src_o    = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            alu_ctrl_o   = 2'b00;
            result_src_o = 2'b00;
            imm_src_o    = 2'b00;
            reg_src_o    = 2'b00;
            illegal_op_o = 1'b0;
            state_o      = 4'd0;
        end
    end

endmodule
